pixel_write_arbiter: RTL

//  Shares the single framebuffer pixel-write port between NREQ object drawers (pipe, bird, score, ...).

---
 rtl/pixel_arb_pkg.sv | 23 ++
 rtl/pixel_write_arbiter_rr_picker.sv | 37 +++
 rtl/pixel_write_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_arb_pkg.sv
// ============================================================================
// Module : pixel_arb_pkg
// Brief  : Shared types and default geometry for the pixel write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pixel_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CLEAR = 2'd2
   } arb_state_e;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_CW       = 11;
   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;

endpackage

`default_nettype wire

// File: rtl/pixel_write_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin pick of the first requester after last_winner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
   parameter int NREQ = 4,
   parameter int LW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last_winner,
   output logic [NREQ-1:0] winner,
   output logic            any
);

   logic [NREQ-1:0] w_hi_mask;
   logic [NREQ-1:0] w_hi_req;
   logic [NREQ-1:0] w_pool;

   // Requesters above the last winner take precedence; otherwise wrap to the lowest.
   always_comb begin
      w_hi_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_hi_mask[i] = (LW'(i) > last_winner);
      end
   end

   assign w_hi_req = req & w_hi_mask;
   assign w_pool   = (|w_hi_req) ? w_hi_req : req;
   assign winner   = w_pool & (~w_pool + {{(NREQ-1){1'b0}}, 1'b1});
   assign any      = |req;

endmodule

`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
// ============================================================================
// Module : pixel_write_arbiter
// Brief  : Round-robin burst arbiter for the framebuffer write port with clear sweep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_write_arbiter
   import pixel_arb_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int CW       = DEF_CW,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  req_last,
   input  logic [NREQ*CW-1:0] req_x,
   input  logic [NREQ*CW-1:0] req_y,
   input  logic [NREQ-1:0]  req_color,
   output logic [NREQ-1:0]  gnt,
   output logic             fb_we,
   output logic [CW-1:0]    fb_x,
   output logic [CW-1:0]    fb_y,
   output logic             fb_color,
   output logic             busy,
   output logic             clear_done
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   generate
      if ((SCREEN_W - 1) >= (2 ** CW) || (SCREEN_H - 1) >= (2 ** CW) || NREQ < 2) begin : g_bad_cfg
         $error("pixel_write_arbiter: screen size does not fit CW or NREQ < 2");
      end
   endgenerate

   arb_state_e      r_state, w_state_nxt;
   logic [NREQ-1:0] r_gnt, w_gnt_nxt;
   logic [LW-1:0]   r_last_winner, w_last_winner_nxt;
   logic            r_clear_pending, w_clear_pending_nxt;
   logic [CW-1:0]   r_sx, r_sy, w_sx_nxt, w_sy_nxt;
   logic            r_fb_we, w_fb_we_nxt;
   logic [CW-1:0]   r_fb_x, r_fb_y, w_fb_x_nxt, w_fb_y_nxt;
   logic            r_fb_color, w_fb_color_nxt;
   logic            r_clear_done, w_clear_done_nxt;

   logic [NREQ-1:0] w_winner;
   logic            w_any;
   logic            w_accept;
   logic            w_accept_last;
   logic [CW-1:0]   w_pix_x, w_pix_y;
   logic            w_pix_color;
   logic [LW-1:0]   w_gnt_idx;
   logic            w_sweep_end;
   logic            w_x_end;

   rr_picker #(
      .NREQ (NREQ),
      .LW   (LW)
   ) u_rr_picker (
      .req         (req),
      .last_winner (r_last_winner),
      .winner      (w_winner),
      .any         (w_any)
   );

   // Grant is one-hot, so OR-ing the masked lanes selects the granted pixel.
   always_comb begin
      w_pix_x     = '0;
      w_pix_y     = '0;
      w_pix_color = 1'b0;
      w_gnt_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt[i]) begin
            w_pix_x     = w_pix_x | req_x[i*CW +: CW];
            w_pix_y     = w_pix_y | req_y[i*CW +: CW];
            w_pix_color = w_pix_color | req_color[i];
            w_gnt_idx   = w_gnt_idx | LW'(i);
         end
      end
   end

   assign w_accept      = |(req & r_gnt);
   assign w_accept_last = |(req & req_last & r_gnt);
   assign w_x_end       = (r_sx == CW'(SCREEN_W - 1));
   assign w_sweep_end   = w_x_end && (r_sy == CW'(SCREEN_H - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_clear_pending) begin
               w_state_nxt = CLEAR;
            end else if (w_any) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (w_accept_last) begin
               w_state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (w_sweep_end) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt           = r_gnt;
      w_last_winner_nxt   = r_last_winner;
      w_clear_pending_nxt = r_clear_pending | (frame_start && (r_state != CLEAR));
      w_sx_nxt            = r_sx;
      w_sy_nxt            = r_sy;
      w_fb_we_nxt         = 1'b0;
      w_fb_x_nxt          = r_fb_x;
      w_fb_y_nxt          = r_fb_y;
      w_fb_color_nxt      = r_fb_color;
      w_clear_done_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_clear_pending && w_any) begin
               w_gnt_nxt = w_winner;
            end
         end
         GRANT: begin
            if (w_accept) begin
               w_fb_we_nxt    = 1'b1;
               w_fb_x_nxt     = w_pix_x;
               w_fb_y_nxt     = w_pix_y;
               w_fb_color_nxt = w_pix_color;
            end
            if (w_accept_last) begin
               w_gnt_nxt         = '0;
               w_last_winner_nxt = w_gnt_idx;
            end
         end
         CLEAR: begin
            w_fb_we_nxt    = 1'b1;
            w_fb_x_nxt     = r_sx;
            w_fb_y_nxt     = r_sy;
            w_fb_color_nxt = 1'b0;
            if (w_sweep_end) begin
               w_clear_done_nxt    = 1'b1;
               w_clear_pending_nxt = 1'b0;
               w_sx_nxt            = '0;
               w_sy_nxt            = '0;
            end else if (w_x_end) begin
               w_sx_nxt = '0;
               w_sy_nxt = r_sy + 1'b1;
            end else begin
               w_sx_nxt = r_sx + 1'b1;
            end
         end
         default: begin
            w_gnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt           <= '0;
         r_last_winner   <= LW'(NREQ - 1);
         r_clear_pending <= 1'b1;
         r_sx            <= '0;
         r_sy            <= '0;
         r_fb_we         <= 1'b0;
         r_fb_x          <= '0;
         r_fb_y          <= '0;
         r_fb_color      <= 1'b0;
         r_clear_done    <= 1'b0;
      end else begin
         r_gnt           <= w_gnt_nxt;
         r_last_winner   <= w_last_winner_nxt;
         r_clear_pending <= w_clear_pending_nxt;
         r_sx            <= w_sx_nxt;
         r_sy            <= w_sy_nxt;
         r_fb_we         <= w_fb_we_nxt;
         r_fb_x          <= w_fb_x_nxt;
         r_fb_y          <= w_fb_y_nxt;
         r_fb_color      <= w_fb_color_nxt;
         r_clear_done    <= w_clear_done_nxt;
      end
   end

   assign gnt        = r_gnt;
   assign fb_we      = r_fb_we;
   assign fb_x       = r_fb_x;
   assign fb_y       = r_fb_y;
   assign fb_color   = r_fb_color;
   assign clear_done = r_clear_done;
   assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire
